inst_fifo_sched: RTL and testbench

INST_FIFO_SCHED -- requirements
Module: inst_fifo_sched

---
 rtl/inst_fifo_sched_pkg.sv | 18 +
 rtl/inst_fifo_sched_if.sv | 34 +++
 rtl/rr_arb2.sv | 21 ++
 rtl/inst_fifo_sched.sv | 90 +++++++++
 tb/tb_inst_fifo_sched.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fifo_sched_pkg.sv
// Shared types and constants for the instruction FIFO scheduler.
// The consumer always pops fixed 8-entry blocks; groups are 1..8 entries.
package inst_fifo_sched_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam int READ_BLK     = 8;
    localparam int MAX_GROUP    = 8;
    localparam int FLUSH_CYCLES = 2;

    function automatic logic num_legal(input logic [3:0] n);
        return (n != 4'd0) && (n <= 4'(MAX_GROUP));
    endfunction

endpackage

// File: rtl/inst_fifo_sched_if.sv
// Requester, consumer and FIFO control pins of the scheduler.
// The master side drives requests and the consumer handshake.
interface inst_fifo_sched_if #(
    parameter int CNT_W = 6
);
    logic             req0_valid;
    logic [3:0]       req0_num;
    logic             req0_ready;
    logic             req1_valid;
    logic [3:0]       req1_num;
    logic             req1_ready;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic             fifo_wt;
    logic [3:0]       fifo_num;
    logic             wsel;
    logic             fifo_rd;
    logic             fifo_rstn;
    logic [CNT_W-1:0] occupancy;
    logic             err_illegal;

    modport master (
        output req0_valid, req0_num, req1_valid, req1_num, flush, out_ready,
        input  req0_ready, req1_ready, out_valid, fifo_wt, fifo_num, wsel,
               fifo_rd, fifo_rstn, occupancy, err_illegal
    );

    modport slave (
        input  req0_valid, req0_num, req1_valid, req1_num, flush, out_ready,
        output req0_ready, req1_ready, out_valid, fifo_wt, fifo_num, wsel,
               fifo_rd, fifo_rstn, occupancy, err_illegal
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester not granted last wins.
// The last-grant pointer resets to 1 so requester 0 takes the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) gnt[0] = 1'b1;
        else if (req[1])                 gnt[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn)     last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    end
endmodule

// File: rtl/inst_fifo_sched.sv
// Control for an external multi-write / 8-read instruction FIFO: arbitrates two
// group writers, tracks a shadow occupancy and sequences flushes.
module inst_fifo_sched
    import inst_fifo_sched_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input logic              clk,
    input logic              rstn,
    inst_fifo_sched_if.slave bus
);
    localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0] BLK_X   = (CNT_W+1)'(READ_BLK);

    state_t           state;
    logic [1:0]       fcnt;
    logic [CNT_W-1:0] occ;
    logic             err;

    logic             run, rd, legal0, legal1, take_ill;
    logic [CNT_W:0]   room, occ_nxt;
    logic [1:0]       req, gnt;

    // Flush and reset both kill any transfer in the cycle they are seen.
    assign run    = rstn && !bus.flush && (state == ST_RUN);
    assign legal0 = num_legal(bus.req0_num);
    assign legal1 = num_legal(bus.req1_num);

    assign bus.out_valid = rstn && (state == ST_RUN) && (occ >= CNT_W'(READ_BLK));
    assign rd            = bus.out_valid && bus.out_ready && !bus.flush;

    // A same-cycle pop frees its block for the write.
    assign room = DEPTH_X - {1'b0, occ} + (rd ? BLK_X : '0);

    // Illegal groups always compete so they can be consumed and flagged.
    assign req[0] = run && bus.req0_valid && (!legal0 || ((CNT_W+1)'(bus.req0_num) <= room));
    assign req[1] = run && bus.req1_valid && (!legal1 || ((CNT_W+1)'(bus.req1_num) <= room));

    rr_arb2 u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (req),
        .gnt  (gnt)
    );

    assign bus.req0_ready  = gnt[0];
    assign bus.req1_ready  = gnt[1];
    assign bus.fifo_wt     = (gnt[0] && legal0) || (gnt[1] && legal1);
    assign bus.fifo_num    = !bus.fifo_wt ? 4'd0 : (gnt[1] ? bus.req1_num : bus.req0_num);
    assign bus.wsel        = gnt[1];
    assign bus.fifo_rd     = rd;
    assign bus.fifo_rstn   = rstn && (state == ST_RUN);
    assign bus.occupancy   = occ;
    assign bus.err_illegal = err;

    assign take_ill = (|gnt) && !bus.fifo_wt;
    assign occ_nxt  = {1'b0, occ}
                    + (bus.fifo_wt ? (CNT_W+1)'(bus.fifo_num) : '0)
                    - (rd ? BLK_X : '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_FLUSH;
            fcnt  <= 2'd0;
            occ   <= '0;
            err   <= 1'b0;
        end else begin
            if (take_ill) err <= 1'b1;
            if (bus.flush) begin
                state <= ST_FLUSH;
                fcnt  <= 2'd0;
                occ   <= '0;
            end else begin
                case (state)
                    ST_FLUSH: begin
                        occ <= '0;
                        if (fcnt == 2'(FLUSH_CYCLES - 1)) begin
                            state <= ST_RUN;
                            fcnt  <= 2'd0;
                        end else begin
                            fcnt <= fcnt + 2'd1;
                        end
                    end
                    default: occ <= occ_nxt[CNT_W-1:0];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fifo_sched.sv
// Scoreboarded bench for inst_fifo_sched: per-cycle predictions are queued at
// drive time and checked against the DUT on the falling edge.
module tb_inst_fifo_sched;
    import inst_fifo_sched_pkg::*;

    localparam int DEPTH = 32;
    localparam int CNT_W = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    inst_fifo_sched_if #(.CNT_W(CNT_W)) bus ();

    inst_fifo_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic             r0, r1, wt;
        logic [3:0]       num;
        logic             wsel, rd, ov, frstn;
        logic [CNT_W-1:0] occ;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bit m_fl   = 1'b1;
    int m_cnt  = 0;
    int m_occ  = 0;
    bit m_last = 1'b1;
    bit m_err  = 1'b0;

    logic o_r0, o_r1, o_wt, o_wsel, o_rd, o_ov, o_frstn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   room;
        bit   run, l0, l1, e0, e1, g0, g1;
        e     = '0;
        run   = rstn && !m_fl && !bus.flush;
        e.ov  = rstn && !m_fl && (m_occ >= 8);
        e.rd  = e.ov && bus.out_ready && !bus.flush;
        room  = DEPTH - m_occ + (e.rd ? 8 : 0);
        l0    = (bus.req0_num >= 1) && (bus.req0_num <= 8);
        l1    = (bus.req1_num >= 1) && (bus.req1_num <= 8);
        e0    = run && bus.req0_valid && (!l0 || int'(bus.req0_num) <= room);
        e1    = run && bus.req1_valid && (!l1 || int'(bus.req1_num) <= room);
        g0    = e0 && (!e1 || m_last);
        g1    = e1 && !g0;
        e.r0  = g0;
        e.r1  = g1;
        e.wt  = (g0 && l0) || (g1 && l1);
        e.num = !e.wt ? 4'd0 : (g0 ? bus.req0_num : bus.req1_num);
        e.wsel  = g1;
        e.frstn = rstn && !m_fl;
        e.occ   = CNT_W'(m_occ);
        e.err   = m_err;
        return e;
    endfunction

    task automatic drive(input bit v0, input int n0, input bit v1, input int n1,
                         input bit fl, input bit ordy);
        bus.req0_valid = v0; bus.req0_num = 4'(n0);
        bus.req1_valid = v1; bus.req1_num = 4'(n1);
        bus.flush = fl; bus.out_ready = ordy;
    endtask

    // One clock: predict from current inputs, check at negedge, advance model.
    task automatic cyc();
        exp_t e, p;
        e = predict();
        sb.push_back(e);
        @(negedge clk);
        p = sb.pop_front();
        chk("req0_ready", bus.req0_ready, p.r0);
        chk("req1_ready", bus.req1_ready, p.r1);
        chk("fifo_wt", bus.fifo_wt, p.wt);
        chk("fifo_num", bus.fifo_num, p.num);
        chk("wsel", bus.wsel, p.wsel);
        chk("fifo_rd", bus.fifo_rd, p.rd);
        chk("out_valid", bus.out_valid, p.ov);
        chk("fifo_rstn", bus.fifo_rstn, p.frstn);
        chk("occupancy", bus.occupancy, p.occ);
        chk("err_illegal", bus.err_illegal, p.err);
        o_r0 = bus.req0_ready; o_r1 = bus.req1_ready; o_wt = bus.fifo_wt;
        o_wsel = bus.wsel; o_rd = bus.fifo_rd; o_ov = bus.out_valid;
        o_frstn = bus.fifo_rstn;
        @(posedge clk);
        if (!rstn) begin
            m_fl = 1; m_cnt = 0; m_occ = 0; m_err = 0; m_last = 1;
        end else begin
            if (p.r0 || p.r1) m_last = p.r1;
            if ((p.r0 || p.r1) && !p.wt) m_err = 1;
            if (bus.flush) begin
                m_fl = 1; m_cnt = 0; m_occ = 0;
            end else if (m_fl) begin
                m_cnt++;
                if (m_cnt == FLUSH_CYCLES) begin m_fl = 0; m_cnt = 0; end
            end else begin
                m_occ = m_occ + (p.wt ? int'(p.num) : 0) - (p.rd ? 8 : 0);
            end
        end
        #1;
    endtask

    initial begin
        int       gcnt;
        logic [3:0] ws;
        bit       v0, v1;
        int       n0, n1;

        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        // Reset state, with a request pending that must be ignored.
        drive(1, 4, 1, 4, 0, 1);
        repeat (2) cyc();
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_ready", {o_r0, o_r1, o_wt, o_rd, o_ov, o_frstn}, 0);

        // Fill with num=8 from requester 0 after release.
        rstn = 1'b1;
        drive(1, 8, 0, 0, 0, 0);
        gcnt = 0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (o_r0) gcnt++;
            if (i < 2) chk("no_grant_in_flush", o_r0, 0);
        end
        chk("fill_grants", gcnt, 4);
        chk("fill_occ", bus.occupancy, 32);
        chk("full_ready0", o_r0, 0);

        // Full FIFO: a write succeeds only alongside a pop.
        drive(0, 0, 1, 5, 0, 1);
        cyc();
        chk("full_pop_rd", o_rd, 1);
        chk("full_pop_r1", o_r1, 1);
        chk("full_pop_occ", bus.occupancy, 29);

        drive(0, 0, 0, 0, 1, 0); cyc();
        drive(0, 0, 0, 0, 0, 0); repeat (2) cyc();

        // Tie between requesters alternates.
        drive(1, 3, 1, 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            ws[i] = o_wsel;
        end
        chk("rr_wsel", ws, 4'b1010);
        chk("rr_occ", bus.occupancy, 12);

        // Illegal num is consumed without a write and flagged stickily.
        drive(1, 0, 0, 0, 0, 0); cyc();
        chk("ill_ready", o_r0, 1);
        chk("ill_wt", o_wt, 0);
        chk("ill_err", bus.err_illegal, 1);
        drive(1, 8, 0, 0, 0, 0); cyc();
        chk("ill_occ", bus.occupancy, 20);

        // Flush beats a same-cycle write.
        drive(1, 4, 0, 0, 1, 0); cyc();
        chk("flush_wt", o_wt, 0);
        drive(0, 0, 0, 0, 0, 0);
        cyc(); chk("flush_rstn0", o_frstn, 0);
        cyc(); chk("flush_rstn1", o_frstn, 0);
        chk("flush_occ", bus.occupancy, 0);
        chk("flush_ov", o_ov, 0);
        chk("err_after_flush", bus.err_illegal, 1);

        // Seven entries never offer a block; the eighth does.
        drive(1, 7, 0, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 1); cyc();
        chk("occ7_ov", o_ov, 0);
        chk("occ7_rd", o_rd, 0);
        drive(1, 1, 0, 0, 0, 1); cyc();
        drive(0, 0, 0, 0, 0, 1); cyc();
        chk("occ8_ov", o_ov, 1);
        chk("occ8_rd", o_rd, 1);
        chk("occ8_occ", bus.occupancy, 0);

        // Random traffic; a requester holds its group until accepted.
        v0 = 0; v1 = 0; n0 = 1; n1 = 1;
        for (int i = 0; i < 400; i++) begin
            if (!v0 || o_r0) begin
                v0 = ($urandom_range(0, 3) != 0);
                n0 = ($urandom_range(0, 11) == 0) ? $urandom_range(9, 15) * $urandom_range(0, 1)
                                                   : $urandom_range(1, 8);
            end
            if (!v1 || o_r1) begin
                v1 = ($urandom_range(0, 3) != 0);
                n1 = ($urandom_range(0, 11) == 0) ? $urandom_range(9, 15) * $urandom_range(0, 1)
                                                   : $urandom_range(1, 8);
            end
            rstn = ($urandom_range(0, 149) != 0);
            drive(v0, n0, v1, n1, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
            cyc();
            if (!rstn) begin o_r0 = 1; o_r1 = 1; end
        end
        rstn = 1'b1;
        drive(0, 0, 0, 0, 0, 0); repeat (3) cyc();

        // Reset mid-operation abandons the grant.
        drive(1, 2, 0, 0, 0, 0);
        rstn = 1'b0; cyc();
        chk("midrst_ready", o_r0, 0);
        chk("midrst_wt", o_wt, 0);
        chk("midrst_err", bus.err_illegal, 0);
        rstn = 1'b1;
        repeat (3) cyc();
        chk("post_rst_grant", o_r0, 1);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
